joy_db15_tx: RTL and testbench

Serial responder for the DB15 joystick link: emulates the adapter-side parallel-in/serial-out shift chain that the core-side DB15 reader clocks. Latches two 16-bit joystick words on JOY_LOAD and shifts them out on JOY_DATA, one bit per JOY_CLK rising edge. Used for loopback self-test through USER_IN/USER_OUT and as the bench model for the DB15 reader.

---
 rtl/joy_db15_tx.sv | 125 ++++++++++++
 tb/tb_joy_db15_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - DB15 joystick shift-chain responder; JOY_DB15_TX_FILTER_EN adds input stability filters
// Latches {joystick2, joystick1} while JOY_LOAD is low and shifts it LSB first, active-low, on JOY_CLK rises.
module joy_db15_tx #(
    parameter int FRAME_BITS = 32
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic [5:0]  bit_cnt
);
    typedef enum logic [1:0] {IDLE, LOADING, SHIFTING, DRAINED} state_t;

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    state_t      state, state_nxt;
    logic [31:0] shreg, shreg_nxt;
    logic [5:0]  cnt_nxt;
    logic        done_nxt;
    logic [1:0]  jclk_sync, load_sync;
    logic        jclk_s, load_s, jclk_d, load_d, rise;

    // Sync chains reset to the idle pin levels: clock low, load released
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            jclk_sync <= 2'b00;
            load_sync <= 2'b11;
        end else begin
            jclk_sync <= {jclk_sync[0], JOY_CLK};
            load_sync <= {load_sync[0], JOY_LOAD};
        end
    end

`ifdef JOY_DB15_TX_FILTER_EN
    // Index 0 is JOY_CLK, index 1 is JOY_LOAD; a level is taken after 4 agreeing samples
    logic [1:0] filt;
    logic [1:0] raw;
    logic [1:0] stab_cnt [2];

    assign raw = {load_sync[1], jclk_sync[1]};

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            filt        <= 2'b10;
            stab_cnt[0] <= 2'd0;
            stab_cnt[1] <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    stab_cnt[i] <= 2'd0;
                end else if (stab_cnt[i] == 2'd3) begin
                    filt[i]     <= raw[i];
                    stab_cnt[i] <= 2'd0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 2'd1;
                end
            end
        end
    end

    assign jclk_s = filt[0];
    assign load_s = filt[1];
`else
    assign jclk_s = jclk_sync[1];
    assign load_s = load_sync[1];
`endif

    assign rise = jclk_s & ~jclk_d;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state      <= IDLE;
            shreg      <= 32'd0;
            bit_cnt    <= 6'd0;
            frame_done <= 1'b0;
            jclk_d     <= 1'b0;
            load_d     <= 1'b1;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= cnt_nxt;
            frame_done <= done_nxt;
            jclk_d     <= jclk_s;
            load_d     <= load_s;
        end
    end

    // Load dominates every state; a shift needs load high for this and the previous cycle
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        done_nxt  = 1'b0;
        if (!load_s) begin
            state_nxt = LOADING;
            shreg_nxt = {joystick2, joystick1};
            cnt_nxt   = 6'd0;
        end else begin
            case (state)
                LOADING: state_nxt = SHIFTING;
                SHIFTING: begin
                    if (rise && load_d) begin
                        cnt_nxt = bit_cnt + 6'd1;
                        if (bit_cnt == LAST_BIT) begin
                            // Clear unsent high bits so the line idles at the no-press level
                            shreg_nxt = 32'd0;
                            done_nxt  = 1'b1;
                            state_nxt = DRAINED;
                        end else begin
                            shreg_nxt = {1'b0, shreg[31:1]};
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    assign JOY_DATA = ~shreg[0];

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - self-checking bench for joy_db15_tx against a pin-delay/frame-index model
module tb_joy_db15_tx;
    localparam int FB = 32;
`ifdef JOY_DB15_TX_FILTER_EN
    localparam int LAT = 7, MINPH = 8, LDMIN = 7, FILT = 1;
`else
    localparam int LAT = 3, MINPH = 4, LDMIN = 3, FILT = 0;
`endif
    localparam int D = LAT - 1;

    logic        clk, reset_l, JOY_CLK, JOY_LOAD, JOY_DATA, frame_done;
    logic [15:0] joystick1, joystick2;
    logic [5:0]  bit_cnt;

    logic        mdl_clk, mdl_load;
    logic [7:0]  hc, hl;
    logic [31:0] m_frame;
    int          m_idx;
    logic        m_valid, m_done;

    int          n_checks, n_err, done_seen;
    logic        chk_en;
    logic [31:0] obs_word;
    int          b0;

    joy_db15_tx #(.FRAME_BITS(FB)) dut (
        .clk(clk), .reset_l(reset_l), .joystick1(joystick1), .joystick2(joystick2),
        .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA),
        .frame_done(frame_done), .bit_cnt(bit_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the design sees each pin LAT-1 samples late; a frame is a word plus a bit index
    initial begin
        hc = 8'h00; hl = 8'hFF; m_valid = 0; m_idx = 0; m_done = 0; m_frame = 0;
        forever begin
            @(posedge clk);
            hc = {hc[6:0], mdl_clk};
            hl = {hl[6:0], mdl_load};
            if (!reset_l) begin
                hc = 8'h00; hl = 8'hFF; m_valid = 0; m_idx = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (!hl[D]) begin
                    m_frame = {joystick2, joystick1};
                    m_idx   = 0;
                    m_valid = 1;
                end else if (m_valid && m_idx < FB && hc[D] && !hc[D+1] && hl[D+1]) begin
                    m_idx++;
                    m_done = (m_idx == FB);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_data", {31'd0, JOY_DATA},
                      {31'd0, (m_valid && m_idx < FB) ? ~m_frame[m_idx] : 1'b1});
                check("cyc_cnt", {26'd0, bit_cnt}, m_idx);
                check("cyc_done", {31'd0, frame_done}, {31'd0, m_done});
                if (frame_done === 1'b1) done_seen++;
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_clk(input logic v);
        JOY_CLK = v;
        mdl_clk = v;
    endtask

    task automatic pulse(input int half);
        set_clk(1'b1);
        wait_n(half);
        set_clk(1'b0);
        wait_n(half);
    endtask

    task automatic do_load(input logic [15:0] j1, input logic [15:0] j2, input int low);
        joystick1 = j1;
        joystick2 = j2;
        JOY_LOAD = 1'b0; mdl_load = 1'b0;
        wait_n(low);
        JOY_LOAD = 1'b1; mdl_load = 1'b1;
        wait_n(LAT + 1);
    endtask

    task automatic obs_bits(input int first, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            obs_word[first + i] = JOY_DATA;
            pulse(half);
        end
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        wait_n(1);
        reset_l = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_err = 0; done_seen = 0; chk_en = 0; obs_word = 0;
        reset_l = 1'b0; JOY_CLK = 1'b0; mdl_clk = 1'b0; JOY_LOAD = 1'b1; mdl_load = 1'b1;
        joystick1 = 16'h0; joystick2 = 16'h0;
        wait_n(3);
        reset_l = 1'b1;
        chk_en = 1'b1;
        wait_n(2);
        check("reset_data", {31'd0, JOY_DATA}, 32'd1);
        check("reset_cnt", {26'd0, bit_cnt}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);

        // Full frame with the 32nd update inspected edge by edge
        done_seen = 0;
        do_load(16'h0005, 16'h8000, LDMIN + 1);
        obs_bits(0, 31, 8);
        obs_word[31] = JOY_DATA;
        set_clk(1'b1);
        wait_n(LAT - 1);
        check("last_pre_cnt", {26'd0, bit_cnt}, 32'd31);
        check("last_pre_done", done_seen, 32'd0);
        wait_n(1);
        check("last_done", {31'd0, frame_done}, 32'd1);
        check("last_cnt", {26'd0, bit_cnt}, 32'd32);
        check("last_data", {31'd0, JOY_DATA}, 32'd1);
        wait_n(8 - LAT);
        set_clk(1'b0);
        wait_n(8);
        check("full_word", obs_word, 32'h7FFF_FFFA);
        check("full_done_count", done_seen, 32'd1);

        // Overclock past the end of the frame
        for (int i = 0; i < 5; i++) pulse(8);
        check("over_cnt", {26'd0, bit_cnt}, 32'd32);
        check("over_data", {31'd0, JOY_DATA}, 32'd1);
        check("over_done_count", done_seen, 32'd1);

        // Load abort after 10 shifts, then a complete fresh frame
        do_load(16'h3C3C, 16'hFFFF, LDMIN + 1);
        for (int i = 0; i < 10; i++) pulse(8);
        check("abort_pre_cnt", {26'd0, bit_cnt}, 32'd10);
        do_load(16'h0001, 16'h1234, (FILT != 0) ? 8 : 4);
        check("abort_cnt", {26'd0, bit_cnt}, 32'd0);
        check("abort_data", {31'd0, JOY_DATA}, 32'd0);
        done_seen = 0;
        obs_bits(0, 32, 8);
        check("abort_word", obs_word, 32'hEDCB_FFFE);
        check("abort_done_count", done_seen, 32'd1);

        // Reset mid-frame, then edges without a load
        do_load(16'hA5A5, 16'h5A5A, LDMIN);
        for (int i = 0; i < 10; i++) pulse(MINPH);
        do_reset();
        wait_n(4);
        check("rst_mid_data", {31'd0, JOY_DATA}, 32'd1);
        check("rst_mid_cnt", {26'd0, bit_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) pulse(8);
        check("rst_noload_cnt", {26'd0, bit_cnt}, 32'd0);
        check("rst_noload_data", {31'd0, JOY_DATA}, 32'd1);

        // JOY_CLK rising together with JOY_LOAD
        joystick1 = 16'h00FF; joystick2 = 16'h0;
        JOY_LOAD = 1'b0; mdl_load = 1'b0;
        wait_n(LDMIN + 1);
        JOY_LOAD = 1'b1; mdl_load = 1'b1;
        set_clk(1'b1);
        wait_n(8);
        set_clk(1'b0);
        wait_n(8);
        check("dom_cnt", {26'd0, bit_cnt}, 32'd0);

        // Input change mid-frame does not alter the frame in flight
        do_load(16'h0000, 16'h0000, LDMIN + 1);
        obs_bits(0, 3, 8);
        joystick1 = 16'hFFFF;
        obs_bits(3, 29, 8);
        check("midchg_word", obs_word, 32'hFFFF_FFFF);

        // Short glitch and minimum pulse on JOY_CLK
        do_load(16'h0002, 16'h0000, LDMIN + 1);
        b0 = int'(bit_cnt);
        JOY_CLK = 1'b1;
        if (FILT == 0) mdl_clk = 1'b1;
        wait_n(2);
        set_clk(1'b0);
        wait_n(12);
        check("glitch_cnt", {26'd0, bit_cnt}, b0 + ((FILT != 0) ? 0 : 1));
        b0 = int'(bit_cnt);
        set_clk(1'b1);
        wait_n(LAT - 1);
        check("lat_pre_cnt", {26'd0, bit_cnt}, b0);
        wait_n(1);
        check("lat_cnt", {26'd0, bit_cnt}, b0 + 1);
        wait_n(4 - LAT > 0 ? 4 - LAT : 0);
        set_clk(1'b0);
        wait_n(12);

        // Randomized frames, aborts, input changes and resets against the model
        for (int f = 0; f < 25; f++) begin
            int n;
            do_load(16'($urandom), 16'($urandom), LDMIN + $urandom_range(0, 4));
            n = $urandom_range(0, 40);
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(0, 15) == 0) begin
                    joystick1 = 16'($urandom);
                    joystick2 = 16'($urandom);
                end
                pulse(MINPH + $urandom_range(0, 4));
            end
            if ($urandom_range(0, 9) == 0) begin
                do_reset();
                wait_n(LAT + 2);
            end
        end

        wait_n(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
